// File: rtl/board_ctrl_if.sv
// Signal bundle between the tic-tac-toe board controller and its UI / draw stages.
// sel_valid is a level click request with no ready: the controller reacts only to its
// rising edge, and each accepted/rejected event is answered by a one-cycle move_ack/move_err.
interface board_ctrl_if;
  logic       start_en;
  logic       choice_en;
  logic       sel_valid;
  logic [3:0] sel_idx;
  logic [8:0] square;
  logic [8:0] square_color;
  logic       turn;
  logic       move_ack;
  logic       move_err;
  logic       game_over;
  logic [1:0] winner;

  modport master (
    output start_en, choice_en, sel_valid, sel_idx,
    input  square, square_color, turn, move_ack, move_err, game_over, winner
  );

  modport slave (
    input  start_en, choice_en, sel_valid, sel_idx,
    output square, square_color, turn, move_ack, move_err, game_over, winner
  );
endinterface

// File: rtl/board_ctrl.sv
// Tic-tac-toe board controller: takes click events, keeps occupancy/ownership,
// alternates players and detects win/draw. All outputs are registered.
module board_ctrl (
  input  logic        pclk,
  input  logic        rst,
  board_ctrl_if.slave bus,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_MOVE = 2'd1,
    CHECK     = 2'd2,
    OVER      = 2'd3
  } state_e;

  // Line masks over the 9-bit board, bit k-1 = square k.
  localparam logic [8:0] LINES [8] = '{
    9'h007, 9'h038, 9'h1C0,
    9'h049, 9'h092, 9'h124,
    9'h111, 9'h054
  };

  state_e     state_q;
  logic       sel_valid_q;
  logic [8:0] square_q;
  logic [8:0] color_q;
  logic       turn_q;
  logic       ack_q;
  logic       err_q;
  logic       over_q;
  logic [1:0] winner_q;
  logic [3:0] count_q;

  logic       click_ev;
  logic       idx_ok;
  logic       sq_free;
  logic       quit_game;
  logic [8:0] sel_mask;
  logic [8:0] own;
  logic       win;

  assign click_ev  = bus.sel_valid & ~sel_valid_q;
  assign idx_ok    = (bus.sel_idx != 4'd0) && (bus.sel_idx <= 4'd9);
  assign sel_mask  = 9'd1 << (bus.sel_idx - 4'd1);
  assign sq_free   = (square_q & sel_mask) == 9'd0;
  assign quit_game = bus.choice_en | ~bus.start_en;
  assign own       = square_q & (turn_q ? color_q : ~color_q);

  always_comb begin
    win = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if ((own & LINES[i]) == LINES[i]) win = 1'b1;
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_valid_q <= 1'b0;
      square_q    <= 9'd0;
      color_q     <= 9'd0;
      turn_q      <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      over_q      <= 1'b0;
      winner_q    <= 2'b00;
      count_q     <= 4'd0;
    end else begin
      sel_valid_q <= bus.sel_valid;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start_en && !bus.choice_en) begin
            square_q <= 9'd0;
            color_q  <= 9'd0;
            count_q  <= 4'd0;
            winner_q <= 2'b00;
            over_q   <= 1'b0;
            turn_q   <= 1'b0;
            state_q  <= WAIT_MOVE;
          end
        end
        WAIT_MOVE: begin
          // Leaving the game wins over a click landing on the same edge.
          if (quit_game) begin
            state_q <= IDLE;
          end else if (click_ev) begin
            if (idx_ok && sq_free) begin
              square_q <= square_q | sel_mask;
              color_q  <= turn_q ? (color_q | sel_mask) : (color_q & ~sel_mask);
              count_q  <= count_q + 4'd1;
              ack_q    <= 1'b1;
              state_q  <= CHECK;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        CHECK: begin
          if (quit_game) begin
            state_q <= IDLE;
          end else if (win) begin
            winner_q <= turn_q ? 2'b10 : 2'b01;
            over_q   <= 1'b1;
            state_q  <= OVER;
          end else if (count_q == 4'd9) begin
            winner_q <= 2'b11;
            over_q   <= 1'b1;
            state_q  <= OVER;
          end else begin
            turn_q  <= ~turn_q;
            state_q <= WAIT_MOVE;
          end
        end
        OVER: begin
          if (!bus.start_en) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.square       = square_q;
  assign bus.square_color = color_q;
  assign bus.turn         = turn_q;
  assign bus.move_ack     = ack_q;
  assign bus.move_err     = err_q;
  assign bus.game_over    = over_q;
  assign bus.winner       = winner_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_board_ctrl.sv
// Bench for board_ctrl: directed vector table, hand sequences for multi-cycle corners,
// and random games scored against an array-based game model.
module tb_board_ctrl;

  logic       pclk;
  logic       rst;
  logic [1:0] dbg_state;
  board_ctrl_if bus ();

  board_ctrl dut (
    .pclk        (pclk),
    .rst         (rst),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_tests = 0;
  int n_fail  = 0;

  // Record layout: {ack, err, square, square_color, turn, winner, game_over}
  logic [23:0] exp_q[$];

  typedef struct {
    logic        restart;
    logic [3:0]  idx;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs [9];

  // ---------------- reference model ----------------
  int   m_board [9];   // 0 empty, 1 blue, 2 yellow
  logic m_turn;
  int   m_moves;
  logic m_over;
  logic [1:0] m_win;
  int win_lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                           '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  function automatic logic [23:0] mk(logic a, logic e, logic [8:0] sq, logic [8:0] col,
                                     logic t, logic [1:0] w, logic o);
    return {a, e, sq, col, t, w, o};
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 9; i++) m_board[i] = 0;
    m_turn = 1'b0; m_moves = 0; m_over = 1'b0; m_win = 2'b00;
  endfunction

  function automatic logic m_has_line(int p);
    for (int l = 0; l < 8; l++)
      if (m_board[win_lines[l][0]] == p && m_board[win_lines[l][1]] == p &&
          m_board[win_lines[l][2]] == p) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [23:0] m_click(int idx);
    logic a = 1'b0;
    logic e = 1'b0;
    logic [8:0] sq = '0;
    logic [8:0] col = '0;
    int p;
    if (!m_over) begin
      if (idx >= 1 && idx <= 9 && m_board[idx-1] == 0) begin
        a = 1'b1;
        p = m_turn ? 2 : 1;
        m_board[idx-1] = p;
        m_moves++;
        if (m_has_line(p)) begin
          m_over = 1'b1; m_win = m_turn ? 2'b10 : 2'b01;
        end else if (m_moves == 9) begin
          m_over = 1'b1; m_win = 2'b11;
        end else begin
          m_turn = ~m_turn;
        end
      end else begin
        e = 1'b1;
      end
    end
    for (int i = 0; i < 9; i++) begin
      sq[i]  = (m_board[i] != 0);
      col[i] = (m_board[i] == 2);
    end
    return mk(a, e, sq, col, m_turn, m_win, m_over);
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [21:0] status();
    return {bus.square, bus.square_color, bus.turn, bus.winner, bus.game_over};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic click_raw(input logic [3:0] idx, output logic a, output logic e);
    @(negedge pclk);
    bus.sel_valid = 1'b1;
    bus.sel_idx   = idx;
    @(negedge pclk);
    a = bus.move_ack;
    e = bus.move_err;
    bus.sel_valid = 1'b0;
    @(negedge pclk);
  endtask

  task automatic do_click(input logic [3:0] idx, input string name);
    logic a, e;
    logic [23:0] exp;
    click_raw(idx, a, e);
    if (exp_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s: no expected record queued", name);
    end else begin
      exp = exp_q.pop_front();
      check(name, {8'd0, a, e, status()}, {8'd0, exp});
    end
  endtask

  task automatic do_restart(input string name);
    @(negedge pclk);
    bus.start_en  = 1'b0;
    bus.choice_en = 1'b0;
    repeat (2) @(negedge pclk);
    bus.start_en = 1'b1;
    repeat (2) @(negedge pclk);
    m_reset();
    check(name, {10'd0, status()}, 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic a, e;
    int   acks, errs;

    // Row win then rejects, hand-derived expectations.
    vecs[0] = '{1'b1, 4'd1,  mk(1,0,9'h001,9'h000,1'b1,2'b00,1'b0)};
    vecs[1] = '{1'b0, 4'd4,  mk(1,0,9'h009,9'h008,1'b0,2'b00,1'b0)};
    vecs[2] = '{1'b0, 4'd2,  mk(1,0,9'h00B,9'h008,1'b1,2'b00,1'b0)};
    vecs[3] = '{1'b0, 4'd5,  mk(1,0,9'h01B,9'h018,1'b0,2'b00,1'b0)};
    vecs[4] = '{1'b0, 4'd3,  mk(1,0,9'h01F,9'h018,1'b0,2'b01,1'b1)};
    vecs[5] = '{1'b1, 4'd5,  mk(1,0,9'h010,9'h000,1'b1,2'b00,1'b0)};
    vecs[6] = '{1'b0, 4'd5,  mk(0,1,9'h010,9'h000,1'b1,2'b00,1'b0)};
    vecs[7] = '{1'b0, 4'd0,  mk(0,1,9'h010,9'h000,1'b1,2'b00,1'b0)};
    vecs[8] = '{1'b0, 4'd12, mk(0,1,9'h010,9'h000,1'b1,2'b00,1'b0)};

    rst = 1'b0;
    bus.start_en  = 1'b0;
    bus.choice_en = 1'b0;
    bus.sel_valid = 1'b0;
    bus.sel_idx   = 4'd0;
    #2 rst = 1'b1;
    #1;
    check("reset_outputs", {8'd0, bus.move_ack, bus.move_err, status()}, 32'd0);
    check("reset_state", {30'd0, dbg_state}, 32'd0);
    repeat (2) @(negedge pclk);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].restart) do_restart($sformatf("vec%0d_restart", i));
      exp_q.push_back(vecs[i].exp);
      do_click(vecs[i].idx, $sformatf("vec%0d", i));
    end

    // Draw game, then clicks after game over are ignored.
    do_restart("draw_restart");
    acks = 0;
    foreach (vecs[i]) begin end
    begin
      int seq [8] = '{1, 2, 3, 5, 4, 6, 8, 7};
      for (int i = 0; i < 8; i++) begin
        click_raw(4'(seq[i]), a, e);
        acks += int'(a);
      end
    end
    check("draw_acks8", acks, 8);
    exp_q.push_back(mk(1,0,9'h1FF,9'h072,1'b0,2'b11,1'b1));
    do_click(4'd9, "draw_last");
    exp_q.push_back(mk(0,0,9'h1FF,9'h072,1'b0,2'b11,1'b1));
    do_click(4'd4, "draw_post1");
    exp_q.push_back(mk(0,0,9'h1FF,9'h072,1'b0,2'b11,1'b1));
    do_click(4'd0, "draw_post2");

    // Held click: one event only.
    do_restart("held_restart");
    acks = 0; errs = 0;
    @(negedge pclk);
    bus.sel_valid = 1'b1;
    bus.sel_idx   = 4'd5;
    repeat (50) begin
      @(negedge pclk);
      acks += int'(bus.move_ack);
      errs += int'(bus.move_err);
    end
    bus.sel_valid = 1'b0;
    check("held_acks", acks, 1);
    check("held_errs", errs, 0);
    check("held_square", {23'd0, bus.square}, 32'h010);
    exp_q.push_back(mk(1,0,9'h011,9'h001,1'b0,2'b00,1'b0));
    do_click(4'd1, "held_next");

    // choice_en pulse forces IDLE, board held, then re-entry clears it.
    bus.choice_en = 1'b1;
    @(negedge pclk);
    bus.choice_en = 1'b0;
    check("choice_idle", {30'd0, dbg_state}, 32'd0);
    check("choice_hold", {23'd0, bus.square}, 32'h011);
    @(negedge pclk);
    check("reentry_state", {30'd0, dbg_state}, 32'd1);
    check("reentry_clear", {10'd0, status()}, 32'd0);

    // Asynchronous reset between edges after 4 moves.
    do_restart("arst_restart");
    for (int i = 1; i <= 4; i++) click_raw(4'(i), a, e);
    check("arst_pre", {23'd0, bus.square}, 32'h00F);
    @(negedge pclk);
    #1 rst = 1'b1;
    bus.sel_valid = 1'b1;
    bus.sel_idx   = 4'd9;
    #1;
    check("arst_outputs", {8'd0, bus.move_ack, bus.move_err, status()}, 32'd0);
    @(negedge pclk);
    rst = 1'b0;
    acks = 0; errs = 0;
    repeat (6) begin
      @(negedge pclk);
      acks += int'(bus.move_ack);
      errs += int'(bus.move_err);
    end
    check("arst_held_events", acks + errs, 0);
    bus.sel_valid = 1'b0;
    m_reset();
    exp_q.push_back(mk(1,0,9'h040,9'h000,1'b1,2'b00,1'b0));
    do_click(4'd7, "arst_click7");

    // Random games against the model.
    for (int g = 0; g < 25; g++) begin
      int idx;
      do_restart($sformatf("rnd%0d_restart", g));
      for (int c = 0; c < 16 && !m_over; c++) begin
        idx = $urandom_range(0, 11);
        exp_q.push_back(m_click(idx));
        do_click(4'(idx), $sformatf("rnd%0d_c%0d", g, c));
      end
      for (int c = 0; c < 2; c++) begin
        idx = $urandom_range(1, 9);
        exp_q.push_back(m_click(idx));
        do_click(4'(idx), $sformatf("rnd%0d_x%0d", g, c));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net so a stuck run still reports.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule
